// File: rtl/ref_vol_pkg.sv
// Shared types, default reference constants and helpers for the dynamic reference model.
package ref_vol_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        ON   = 2'd2
    } state_t;

    localparam real DEF_VCM_VOL    = 0.5;
    localparam real DEF_REFP_VOL   = 0.6;
    localparam real DEF_REFN_VOL   = 0.4;
    localparam real DEF_DROOP_FRAC = 0.01;
    localparam real SPAN           = DEF_REFP_VOL - DEF_REFN_VOL;
    localparam real DROOP_STEP     = DEF_DROOP_FRAC * SPAN;

    function automatic real clamp_real(input real x, input real lo, input real hi);
        real r;
        r = x;
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/ref_vol_dyn_if.sv
// Control inputs and real-valued reference outputs between ADC top and reference model.
interface ref_vol_dyn_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned TRIM_BITS = 4
);
    logic                 en;
    logic [TRIM_BITS-1:0] trim_code;
    logic [NUM_CH-1:0]    load;
    real                  vcm   [NUM_CH];
    real                  vrefp [NUM_CH];
    real                  vrefn [NUM_CH];
    logic                 ready;
    logic [NUM_CH-1:0]    settled;

    modport master (
        output en, trim_code, load,
        input  vcm, vrefp, vrefn, ready, settled
    );

    modport slave (
        input  en, trim_code, load,
        output vcm, vrefp, vrefn, ready, settled
    );
endinterface

// File: rtl/ref_droop_ch.sv
// One channel of reference droop: load-driven error with exponential recovery,
// applied symmetrically to vrefp/vrefn around the shared targets.
module ref_droop_ch
    import ref_vol_pkg::*;
#(
    parameter real SPAN_V     = SPAN,
    parameter real DROOP_V    = DROOP_STEP,
    parameter real ALPHA      = 0.5,
    parameter real SETTLE_TOL = 0.0005
) (
    input  logic   clk,
    input  logic   rst_n,
    input  state_t state,
    input  logic   en,
    input  logic   load,
    input  real    tgt_vrefp,
    input  real    tgt_vrefn,
    output real    vrefp,
    output real    vrefn,
    output logic   settled
);
    real err_q;
    real err_d;

    // Error only evolves while ON and enabled; everything else clears it.
    always_comb begin
        err_d = 0.0;
        if (en && (state == ON)) begin
            err_d = clamp_real(err_q * (1.0 - ALPHA) + (load ? DROOP_V : 0.0), 0.0, SPAN_V);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 0.0;
        else        err_q <= err_d;
    end

    assign vrefp   = tgt_vrefp - err_q / 2.0;
    assign vrefn   = tgt_vrefn + err_q / 2.0;
    assign settled = (state == ON) && (err_q <= SETTLE_TOL);

endmodule

// File: rtl/ref_vol_dyn.sv
// Multi-channel dynamic reference: enable ramp, signed common-mode trim and
// per-channel droop, all outputs derived from registered state.
module ref_vol_dyn
    import ref_vol_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter real         VCM_VOL     = DEF_VCM_VOL,
    parameter real         REFP_VOL    = DEF_REFP_VOL,
    parameter real         REFN_VOL    = DEF_REFN_VOL,
    parameter int unsigned STARTUP_CYC = 16,
    parameter int unsigned TRIM_BITS   = 4,
    parameter real         TRIM_LSB    = 0.002,
    parameter real         DROOP_FRAC  = DEF_DROOP_FRAC,
    parameter real         ALPHA       = 0.5,
    parameter real         SETTLE_TOL  = 0.0005
) (
    input logic         clk,
    input logic         rst_n,
    ref_vol_dyn_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(STARTUP_CYC + 2);
    localparam real         SPAN_P   = REFP_VOL - REFN_VOL;
    localparam real         DROOP_P  = DROOP_FRAC * SPAN_P;
    localparam real         RAMP_DIV = (STARTUP_CYC == 0) ? 1.0 : real'(STARTUP_CYC);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    real                          t_q;
    logic signed [TRIM_BITS-1:0]  trim_s;
    real                          scale_c;
    real                          vcm_c, refp_c, refn_c;

    assign trim_s = bus.trim_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            t_q     <= 0.0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= real'(trim_s) * TRIM_LSB;
        end
    end

    // Disable dominates; a ramp of one cycle or less lands straight in ON.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.en) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    if (STARTUP_CYC <= 1) begin
                        state_d = ON;
                        cnt_d   = CNT_W'(STARTUP_CYC);
                    end else begin
                        state_d = RAMP;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RAMP: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d >= CNT_W'(STARTUP_CYC)) state_d = ON;
                end
                ON: begin
                    state_d = ON;
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        scale_c = 0.0;
        case (state_q)
            RAMP:    scale_c = real'(cnt_q) / RAMP_DIV;
            ON:      scale_c = 1.0;
            default: scale_c = 0.0;
        endcase
    end

    assign vcm_c  = (VCM_VOL  + t_q) * scale_c;
    assign refp_c = (REFP_VOL + t_q) * scale_c;
    assign refn_c = (REFN_VOL + t_q) * scale_c;

    assign bus.ready = (state_q == ON);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign bus.vcm[g] = vcm_c;

        ref_droop_ch #(
            .SPAN_V     (SPAN_P),
            .DROOP_V    (DROOP_P),
            .ALPHA      (ALPHA),
            .SETTLE_TOL (SETTLE_TOL)
        ) u_droop (
            .clk       (clk),
            .rst_n     (rst_n),
            .state     (state_q),
            .en        (bus.en),
            .load      (bus.load[g]),
            .tgt_vrefp (refp_c),
            .tgt_vrefn (refn_c),
            .vrefp     (bus.vrefp[g]),
            .vrefn     (bus.vrefn[g]),
            .settled   (bus.settled[g])
        );
    end

endmodule

// File: tb/tb_ref_vol_dyn.sv
// Bench for ref_vol_dyn: behavioural model based on cycles-since-enable, checked every cycle.
module tb_ref_vol_dyn;
    localparam int  NCH  = 4;
    localparam int  TBW  = 4;
    localparam int  SC   = 16;
    localparam real TOL  = 1e-9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ref_vol_dyn_if #(.NUM_CH(NCH), .TRIM_BITS(TBW)) bus ();

    ref_vol_dyn #(.NUM_CH(NCH), .TRIM_BITS(TBW), .STARTUP_CYC(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    // Model: number of enabled edges since the last disable, droop error, trim voltage.
    int  m_since;
    real m_err [NCH];
    real m_t;

    task automatic chk_r(input string nm, input real act, input real exp);
        total++;
        if ((act - exp > TOL) || (exp - act > TOL)) begin
            bad++;
            $display("FAIL %s: got %.9f want %.9f at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_since = 0;
            m_t     = 0.0;
            foreach (m_err[i]) m_err[i] = 0.0;
        end else begin
            logic signed [TBW-1:0] ts;
            real e;
            ts = bus.trim_code;
            if (!bus.en) begin
                m_since = 0;
                foreach (m_err[i]) m_err[i] = 0.0;
            end else begin
                if (m_since >= SC) begin
                    foreach (m_err[i]) begin
                        e = m_err[i] * 0.5 + (bus.load[i] ? 0.01 * (0.6 - 0.4) : 0.0);
                        if (e > 0.6 - 0.4) e = 0.6 - 0.4;
                        if (e < 0.0) e = 0.0;
                        m_err[i] = e;
                    end
                end
                m_since = (m_since + 1 > SC) ? SC : m_since + 1;
            end
            m_t = real'(int'(ts)) * 0.002;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            real lvl;
            bit  on;
            on  = (m_since >= SC);
            lvl = on ? 1.0 : real'(m_since) / real'(SC);
            for (int i = 0; i < NCH; i++) begin
                chk_r($sformatf("vcm[%0d]", i),   bus.vcm[i],   (0.5 + m_t) * lvl);
                chk_r($sformatf("vrefp[%0d]", i), bus.vrefp[i], (0.6 + m_t) * lvl - m_err[i] / 2.0);
                chk_r($sformatf("vrefn[%0d]", i), bus.vrefn[i], (0.4 + m_t) * lvl + m_err[i] / 2.0);
                chk_b($sformatf("settled[%0d]", i), 32'(bus.settled[i]),
                      32'(on && (m_err[i] <= 0.0005)));
            end
            chk_b("ready", 32'(bus.ready), 32'(on));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.trim_code = '0;
        bus.load      = '0;
        #12;
        chk_r("rst_vcm", bus.vcm[0], 0.0);
        chk_r("rst_vrefp", bus.vrefp[3], 0.0);
        chk_b("rst_ready", 32'(bus.ready), 32'd0);
        chk_b("rst_settled", 32'(bus.settled), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(5);
        chk_r("idle_vrefn", bus.vrefn[1], 0.0);
        chk_b("idle_ready", 32'(bus.ready), 32'd0);

        // Ramp
        bus.en = 1'b1;
        step(4);
        chk_r("ramp4_vcm", bus.vcm[0], 0.125);
        chk_r("ramp4_vrefp", bus.vrefp[0], 0.15);
        chk_r("ramp4_vrefn", bus.vrefn[0], 0.1);
        chk_b("ramp4_ready", 32'(bus.ready), 32'd0);
        step(12);
        chk_r("on_vcm", bus.vcm[2], 0.5);
        chk_r("on_vrefp", bus.vrefp[2], 0.6);
        chk_r("on_vrefn", bus.vrefn[2], 0.4);
        chk_b("on_ready", 32'(bus.ready), 32'd1);
        chk_b("on_settled", 32'(bus.settled), 32'hf);

        // Single droop on channel 0
        bus.load = 4'b0001;
        step(1);
        bus.load = 4'b0000;
        chk_r("droop_vrefp0", bus.vrefp[0], 0.599);
        chk_r("droop_vrefn0", bus.vrefn[0], 0.401);
        chk_b("droop_settled0", 32'(bus.settled[0]), 32'd0);
        chk_r("droop_vrefp1", bus.vrefp[1], 0.6);
        step(1);
        chk_r("rec1_vrefp0", bus.vrefp[0], 0.5995);
        chk_r("rec1_vrefn0", bus.vrefn[0], 0.4005);
        step(1);
        chk_r("rec2_vrefp0", bus.vrefp[0], 0.59975);
        chk_b("rec2_settled", 32'(bus.settled), 32'hf);

        // Saturation on channel 2
        bus.load = 4'b0100;
        step(200);
        chk_r("sat_vrefp2", bus.vrefp[2], 0.598);
        chk_r("sat_vrefn2", bus.vrefn[2], 0.402);
        chk_b("sat_settled", 32'(bus.settled), 32'b1011);
        bus.load = 4'b0000;
        step(30);

        // Trim -3
        bus.trim_code = 4'b1101;
        step(1);
        chk_r("trim_vcm", bus.vcm[1], 0.494);
        chk_r("trim_vrefp", bus.vrefp[1], 0.594);
        chk_r("trim_vrefn", bus.vrefn[1], 0.394);

        // Randomised traffic with occasional disables and trim changes
        for (int k = 0; k < 400; k++) begin
            bus.load = 4'($urandom);
            if ($urandom_range(0, 9) == 0) bus.trim_code = 4'($urandom);
            bus.en = ($urandom_range(0, 59) != 0);
            step(1);
        end

        // Abort in ON with simultaneous loads
        bus.en        = 1'b1;
        bus.trim_code = '0;
        bus.load      = '0;
        step(20);
        bus.load = 4'b1111;
        bus.en   = 1'b0;
        step(1);
        bus.load = '0;
        chk_r("abort_vcm", bus.vcm[0], 0.0);
        chk_r("abort_vrefp", bus.vrefp[3], 0.0);
        chk_b("abort_ready", 32'(bus.ready), 32'd0);
        bus.en = 1'b1;
        step(16);
        chk_r("reen_vrefp3", bus.vrefp[3], 0.6);
        chk_b("reen_ready", 32'(bus.ready), 32'd1);

        // Asynchronous reset mid-ramp
        bus.en = 1'b0;
        step(1);
        bus.en = 1'b1;
        step(5);
        chk_r("pre_rst_vcm", bus.vcm[1], 0.5 * 5.0 / 16.0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_r("async_vcm", bus.vcm[1], 0.0);
        chk_r("async_vrefp", bus.vrefp[1], 0.0);
        chk_b("async_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1);
        chk_r("restart_vcm", bus.vcm[0], 0.03125);
        chk_r("restart_vrefp", bus.vrefp[0], 0.0375);
        step(20);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
